ifetch_unit: RTL and testbench

Instruction fetch unit at the producer end of the decode interface. It drives the opcode and instruction into the control/decode stage and consumes the branch decision (`Branch`) that stage returns. It fetches sequential 32-bit words from instruction memory through a req/gnt/rvalid handshake and buffers them in a small FIFO. On a taken branch it redirects the PC and discards stale instructions.

---
 rtl/ifetch_unit_if.sv | 31 +++
 rtl/ifetch_unit.sv | 158 +++++++++++++++
 tb/tb_ifetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bundle: instruction-memory req/gnt/rvalid port plus the decode-side instruction/branch port.
// Suffixes are from the fetch unit's point of view; the unit binds the master modport.
interface ifetch_unit_if #(
   parameter int ADDR_W = 32
);
   logic              start_i;
   logic              imem_req_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic              imem_gnt_i;
   logic              imem_rvalid_i;
   logic [31:0]       imem_rdata_i;
   logic              inst_valid_o;
   logic              inst_ready_i;
   logic [31:0]       inst_o;
   logic [6:0]        op_o;
   logic [ADDR_W-1:0] inst_pc_o;
   logic              branch_i;
   logic [ADDR_W-1:0] branch_target_i;

   modport master (
      input  start_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      input  inst_ready_i, branch_i, branch_target_i,
      output imem_req_o, imem_addr_o, inst_valid_o, inst_o, op_o, inst_pc_o
   );

   modport slave (
      output start_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
      output inst_ready_i, branch_i, branch_target_i,
      input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, op_o, inst_pc_o
   );
endinterface

// File: rtl/ifetch_unit.sv
// Sequential instruction fetcher: one outstanding imem request, small shift FIFO towards decode,
// branch redirect that never disturbs an ungranted request (stale responses are drained instead).
module ifetch_unit #(
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BOOT_ADDR = ADDR_W'(32'h0000_0000),
   parameter int                DEPTH     = 2
) (
   input logic           clk_i,
   input logic           rst_i,
   ifetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t            state_q;
   logic              req_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic              redir_q;
   logic [ADDR_W-1:0] redir_pc_q;

   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic              valid_q;
   logic [31:0]       data_q [DEPTH];
   logic [31:0]       data_d [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [ADDR_W-1:0] pc_d   [DEPTH];

   logic              flush;
   logic              pop;
   logic              push;
   logic              space_d;
   logic [CW-1:0]     wr_idx;
   logic [ADDR_W-1:0] target;

   assign flush  = bus.branch_i;
   assign target = bus.branch_target_i & ~ADDR_W'(3);
   assign pop    = valid_q & bus.inst_ready_i;
   assign push   = (state_q == ST_WAIT) & bus.imem_rvalid_i & ~flush;
   assign wr_idx = count_q - CW'(pop);

   // A taken branch overrides any push/pop that lands in the same cycle.
   always_comb begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (flush) begin
         count_d = '0;
      end
   end

   assign space_d = (count_d < CW'(DEPTH));

   // Entry 0 is always the head, so the decode-side outputs come straight from flops.
   genvar gi;
   for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam int NEXT = (gi < DEPTH - 1) ? gi + 1 : gi;
      logic wr_here;
      assign wr_here    = push && (wr_idx == CW'(gi));
      assign data_d[gi] = wr_here ? bus.imem_rdata_i : (pop ? data_q[NEXT] : data_q[gi]);
      assign pc_d[gi]   = wr_here ? fetch_pc_q       : (pop ? pc_q[NEXT]   : pc_q[gi]);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_q <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         count_q <= count_d;
         valid_q <= (count_d != '0);
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
            pc_q[i]   <= pc_d[i];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         req_q      <= 1'b0;
         fetch_pc_q <= BOOT_ADDR;
         redir_q    <= 1'b0;
         redir_pc_q <= BOOT_ADDR;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (flush) begin
                  fetch_pc_q <= target;
               end
               if (bus.start_i && space_d) begin
                  state_q <= ST_REQ;
                  req_q   <= 1'b1;
               end
            end
            ST_REQ: begin
               // The request on the bus is left alone; the redirect is applied once it has been drained.
               if (flush) begin
                  redir_q    <= 1'b1;
                  redir_pc_q <= target;
               end
               if (bus.imem_gnt_i) begin
                  state_q <= (redir_q || flush) ? ST_DRAIN : ST_WAIT;
                  req_q   <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (bus.imem_rvalid_i) begin
                  fetch_pc_q <= flush ? target : fetch_pc_q + ADDR_W'(4);
                  if (bus.start_i && space_d) begin
                     state_q <= ST_REQ;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (flush) begin
                  redir_q    <= 1'b1;
                  redir_pc_q <= target;
                  state_q    <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (bus.imem_rvalid_i) begin
                  fetch_pc_q <= flush ? target : redir_pc_q;
                  redir_q    <= 1'b0;
                  if (bus.start_i && space_d) begin
                     state_q <= ST_REQ;
                     req_q   <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (flush) begin
                  redir_pc_q <= target;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req_o   = req_q;
   assign bus.imem_addr_o  = fetch_pc_q;
   assign bus.inst_valid_o = valid_q;
   assign bus.inst_o       = data_q[0];
   assign bus.op_o         = data_q[0][6:0];
   assign bus.inst_pc_o    = pc_q[0];
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: behavioural instruction memory with programmable latency and grant hold,
// a scoreboard of expected {pc, data} pairs, and directed branch/reset scenarios.
module tb_ifetch_unit;
   localparam int          ADDR_W = 32;
   localparam logic [31:0] BOOT   = 32'h0000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst_i;

   ifetch_unit_if #(.ADDR_W(ADDR_W)) bus_if ();

   ifetch_unit #(
      .ADDR_W   (ADDR_W),
      .BOOT_ADDR(BOOT),
      .DEPTH    (2)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .bus  (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
      $fatal(1, "timeout");
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int n_gnt    = 0;
   int n_out    = 0;

   bit          start_k, ready_k, br_k, hold_en;
   logic [31:0] br_t, hold_addr;
   int          rv_lat = 1;

   bit          pending, pend_drop, doom_req, prev_ungr, chk_flush;
   int          pend_cnt;
   logic [31:0] pend_addr, doom_addr, exp_fetch, prev_addr;

   exp_t        exp_q[$];
   logic [31:0] gnt_log[$];
   logic [31:0] out_log[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] first_of(input logic [31:0] q[$]);
      if (q.size() == 0) return 32'hFFFF_FFFF;
      return q[0];
   endfunction

   task automatic model_reset();
      pending   = 0;
      pend_drop = 0;
      doom_req  = 0;
      prev_ungr = 0;
      chk_flush = 0;
      exp_q.delete();
      exp_fetch = BOOT;
   endtask

   // One clock: sample outputs at the falling edge, then drive the inputs for the next rising edge.
   task automatic step();
      bit          resp_now, resp_keep, gnt;
      logic [31:0] resp_pc;
      exp_t        e;
      @(negedge clk);
      cyc++;
      resp_now = 0; resp_keep = 0; resp_pc = '0; gnt = 0;
      if (prev_ungr) begin
         check("req_hold", bus_if.imem_req_o, 1'b1);
         check("addr_hold", bus_if.imem_addr_o, prev_addr);
      end
      if (chk_flush) begin
         check("flush_valid", bus_if.inst_valid_o, 1'b0);
         chk_flush = 0;
      end
      bus_if.imem_rvalid_i = 1'b0;
      bus_if.imem_rdata_i  = 32'hDEAD_BEEF;
      if (pending) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            bus_if.imem_rvalid_i = 1'b1;
            bus_if.imem_rdata_i  = mem_data(pend_addr);
            resp_now  = 1;
            resp_keep = !pend_drop;
            resp_pc   = pend_addr;
            pending   = 0;
         end
      end
      if (bus_if.imem_req_o && !(hold_en && bus_if.imem_addr_o == hold_addr)) begin
         gnt = 1;
         n_gnt++;
         check("req_addr", bus_if.imem_addr_o, doom_req ? doom_addr : exp_fetch);
         check("one_outstanding", pending, 1'b0);
         $display("cyc %0d grant addr=%08h", cyc, bus_if.imem_addr_o);
         gnt_log.push_back(bus_if.imem_addr_o);
         pending   = 1;
         pend_addr = bus_if.imem_addr_o;
         pend_cnt  = rv_lat;
         pend_drop = doom_req;
         doom_req  = 0;
      end
      bus_if.imem_gnt_i   = gnt;
      prev_ungr           = bus_if.imem_req_o && !gnt;
      prev_addr           = bus_if.imem_addr_o;
      bus_if.inst_ready_i = ready_k;
      if (bus_if.inst_valid_o && ready_k) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check("spurious_valid", bus_if.inst_valid_o, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("inst_pc", bus_if.inst_pc_o, e.pc);
            check("inst", bus_if.inst_o, e.data);
            check("op", bus_if.op_o, e.data[6:0]);
         end
         $display("cyc %0d inst pc=%08h data=%08h op=%02h", cyc, bus_if.inst_pc_o, bus_if.inst_o, bus_if.op_o);
         out_log.push_back(bus_if.inst_pc_o);
      end
      bus_if.branch_i        = br_k;
      bus_if.branch_target_i = br_t;
      if (br_k) begin
         exp_q.delete();
         resp_keep = 0;
         if (pending) pend_drop = 1;
         if (bus_if.imem_req_o && !gnt) begin
            if (!doom_req) doom_addr = bus_if.imem_addr_o;
            doom_req = 1;
         end
         exp_fetch = {br_t[31:2], 2'b00};
         chk_flush = 1;
         br_k      = 0;
         $display("cyc %0d branch target=%08h", cyc, br_t);
      end
      if (resp_now && resp_keep) begin
         exp_q.push_back('{pc: resp_pc, data: mem_data(resp_pc)});
         exp_fetch = resp_pc + 32'd4;
      end
      bus_if.start_i = start_k;
   endtask

   task automatic do_reset();
      rst_i   = 1'b0;
      start_k = 0;
      hold_en = 0;
      br_k    = 0;
      model_reset();
      repeat (2) step();
      rst_i = 1'b1;
   endtask

   task automatic wait_grant(input string tag, input int lat);
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         seen = pending && pend_cnt == lat;
      end
      check(tag, seen, 1'b1);
   endtask

   initial begin
      int  c0, o0, g0;
      bit  found;
      rst_i                  = 1'b0;
      bus_if.start_i         = 1'b0;
      bus_if.imem_gnt_i      = 1'b0;
      bus_if.imem_rvalid_i   = 1'b0;
      bus_if.imem_rdata_i    = '0;
      bus_if.inst_ready_i    = 1'b0;
      bus_if.branch_i        = 1'b0;
      bus_if.branch_target_i = '0;
      br_t = '0; hold_addr = '0;
      model_reset();
      repeat (3) step();
      check("rst_req", bus_if.imem_req_o, 1'b0);
      check("rst_addr", bus_if.imem_addr_o, BOOT);
      check("rst_valid", bus_if.inst_valid_o, 1'b0);
      check("rst_inst", bus_if.inst_o, 32'h0);
      check("rst_op", bus_if.op_o, 7'h0);
      check("rst_pc", bus_if.inst_pc_o, 32'h0);
      rst_i = 1'b1;

      // Boot with a zero-wait memory
      ready_k = 1; rv_lat = 1; start_k = 1;
      step();
      c0 = cyc;
      for (int i = 0; i < 10 && !bus_if.inst_valid_o; i++) step();
      check("first_valid_lat", cyc - c0, 3);
      repeat (6) step();
      o0 = n_out;
      repeat (20) step();
      check("throughput", n_out - o0, 10);

      // Backpressure: FIFO fills and fetching stops
      do_reset();
      ready_k = 0; start_k = 1; rv_lat = 1;
      g0 = n_gnt;
      repeat (12) step();
      check("bp_valid", bus_if.inst_valid_o, 1'b1);
      check("bp_head_pc", bus_if.inst_pc_o, BOOT);
      check("bp_grants", n_gnt - g0, 2);
      check("bp_no_req", bus_if.imem_req_o, 1'b0);
      gnt_log.delete(); out_log.delete();
      ready_k = 1;
      repeat (10) step();
      check("bp_resume_addr", first_of(gnt_log), 32'h8);
      check("bp_first_out", first_of(out_log), 32'h0);

      // Branch while waiting for a slow response
      rv_lat = 3;
      wait_grant("wb_wait_grant", 3);
      br_k = 1; br_t = 32'h100;
      step();
      gnt_log.delete(); out_log.delete();
      repeat (15) step();
      check("wb_target_addr", first_of(gnt_log), 32'h100);
      check("wb_head_pc", first_of(out_log), 32'h100);

      // Branch while a request waits for its grant
      do_reset();
      ready_k = 1; rv_lat = 1; start_k = 1; hold_en = 1; hold_addr = 32'h8;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         found = bus_if.imem_req_o && bus_if.imem_addr_o == 32'h8;
      end
      check("rb_reach_req8", found, 1'b1);
      br_k = 1; br_t = 32'h203;
      gnt_log.delete();
      step();
      out_log.delete();
      repeat (3) step();
      check("rb_addr_stable", bus_if.imem_addr_o, 32'h8);
      hold_en = 0;
      repeat (15) step();
      check("rb_drained_addr", first_of(gnt_log), 32'h8);
      check("rb_target_addr", gnt_log.size() > 1 ? gnt_log[1] : 32'hFFFF_FFFF, 32'h200);
      check("rb_head_pc", first_of(out_log), 32'h200);

      // Branch on a pop cycle coinciding with rvalid
      do_reset();
      ready_k = 0; rv_lat = 2; start_k = 1;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (pending && pend_cnt == 1 && bus_if.inst_valid_o) begin
            ready_k = 1; br_k = 1; br_t = 32'h300; found = 1;
         end
         step();
      end
      check("pb_found", found, 1'b1);
      gnt_log.delete(); out_log.delete();
      repeat (12) step();
      check("pb_target_addr", first_of(gnt_log), 32'h300);
      check("pb_head_pc", first_of(out_log), 32'h300);

      // Asynchronous reset between grant and response
      ready_k = 1; rv_lat = 3;
      wait_grant("ar_wait_grant", 3);
      @(posedge clk);
      #2 rst_i = 1'b0;
      #1;
      check("ar_req", bus_if.imem_req_o, 1'b0);
      check("ar_addr", bus_if.imem_addr_o, BOOT);
      check("ar_valid", bus_if.inst_valid_o, 1'b0);
      check("ar_inst", bus_if.inst_o, 32'h0);
      check("ar_op", bus_if.op_o, 7'h0);
      check("ar_pc", bus_if.inst_pc_o, 32'h0);
      exp_q.delete();
      exp_fetch = BOOT;
      pend_drop = 1; doom_req = 0; prev_ungr = 0; chk_flush = 0;
      start_k   = 0;
      step();
      rst_i = 1'b1;
      repeat (5) step();
      check("ar_late_valid", bus_if.inst_valid_o, 1'b0);
      check("ar_idle_req", bus_if.imem_req_o, 1'b0);
      start_k = 1;
      gnt_log.delete(); out_log.delete();
      repeat (10) step();
      check("ar_restart_addr", first_of(gnt_log), BOOT);
      check("ar_restart_pc", first_of(out_log), BOOT);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
